// File: rtl/iq_pkg.sv
// Shared types and constants for the two-wide instruction queue.
// The optional same-cycle bypass is enabled by defining INST_QUEUE_BYPASS_EN.
package iq_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int IQ_INST_W        = 96;
  localparam int IQ_PTR_W         = $clog2(IQ_DEPTH_DEFAULT);
  localparam int IQ_CNT_W         = IQ_PTR_W + 1;

  typedef logic [IQ_PTR_W-1:0] iq_ptr_t;
  typedef logic [IQ_CNT_W-1:0] iq_cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [15:0] predecode;
    logic [15:0] bpu_pred;
  } iq_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// DEPTH x INST_W register file: two write ports, two asynchronous read ports.
// Contents are intentionally not reset; validity is tracked by the queue control.
module inst_queue_ram #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 96
) (
  input  logic                     clk,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  logic [INST_W-1:0]        wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  logic [INST_W-1:0]        wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output logic [INST_W-1:0]        rdata0_o,
  output logic [INST_W-1:0]        rdata1_o
);

  logic [INST_W-1:0] mem_q [DEPTH];

  // The two write addresses are always consecutive, so they never collide.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_queue.sv
// Two-wide fetch-to-decode decoupling queue with pointer/count control.
// Define INST_QUEUE_BYPASS_EN for zero-latency forwarding into an empty queue.
module inst_queue
  import iq_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH_DEFAULT,
  parameter int INST_W = IQ_INST_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [2*INST_W-1:0]        enq_inst_i,
  input  logic [1:0]                 enq_valid_i,
  output logic                       enq_ready_o,
  output logic [2*INST_W-1:0]        deq_inst_o,
  output logic [1:0]                 deq_valid_o,
  input  logic [1:0]                 issue_num_i,
  input  logic                       backend_stall_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        issue_eff, n_push, n_pop, n_byp, n_wr;
  logic [INST_W-1:0] slot0, slot1, cmp0, cmp1, wdata0;
  logic [INST_W-1:0] rdata0, rdata1;
  logic              we0, we1, byp_act;

  assign slot0 = enq_inst_i[INST_W-1:0];
  assign slot1 = enq_inst_i[2*INST_W-1:INST_W];
  // Compact valid slots so the oldest valid instruction is always first.
  assign cmp0  = enq_valid_i[0] ? slot0 : slot1;
  assign cmp1  = slot1;

  assign enq_ready_o = (count_q <= CNT_W'(DEPTH - 2));
  assign issue_eff   = (issue_num_i == 2'd3) ? 2'd2 : issue_num_i;
  assign n_push      = enq_ready_o ? popcount2(enq_valid_i) : 2'd0;

`ifdef INST_QUEUE_BYPASS_EN
  assign byp_act = (count_q == '0) && !flush_i;
`else
  assign byp_act = 1'b0;
`endif

  always_comb begin
    n_pop = 2'd0;
    n_byp = 2'd0;
    if (!backend_stall_i) begin
      if (byp_act)
        n_byp = (issue_eff < n_push) ? issue_eff : n_push;
      else if (count_q < CNT_W'(issue_eff))
        n_pop = count_q[1:0];
      else
        n_pop = issue_eff;
    end
    n_wr   = n_push - n_byp;
    wdata0 = (n_byp != 2'd0) ? cmp1 : cmp0;
    we0    = !flush_i && (n_wr != 2'd0);
    we1    = !flush_i && (n_wr == 2'd2);
  end

  always_comb begin
    head_d  = head_q + PTR_W'(n_pop);
    tail_d  = tail_q + PTR_W'(n_wr);
    count_d = count_q + CNT_W'(n_wr) - CNT_W'(n_pop);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  inst_queue_ram #(.DEPTH(DEPTH), .INST_W(INST_W)) u_ram (
    .clk      (clk),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + PTR_W'(1)),
    .wdata1_i (cmp1),
    .raddr0_i (head_q),
    .raddr1_i (head_q + PTR_W'(1)),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  always_comb begin
    deq_inst_o  = {rdata1, rdata0};
    deq_valid_o = {count_q >= CNT_W'(2), count_q >= CNT_W'(1)};
    if (byp_act) begin
      deq_inst_o  = {cmp1, cmp0};
      deq_valid_o = {n_push == 2'd2, n_push != 2'd0};
    end
  end

  assign count_o = count_q;

  a_issue_legal: assert property (@(posedge clk) disable iff (!rst_n) issue_num_i != 2'd3);

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;

  localparam int W = 96;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic [2*W-1:0] enq_inst_i;
  logic [1:0]   enq_valid_i;
  logic         enq_ready_o;
  logic [2*W-1:0] deq_inst_o;
  logic [1:0]   deq_valid_o;
  logic [1:0]   issue_num_i;
  logic         backend_stall_i;
  logic [3:0]   count_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [1:0]   obs_valid;
  logic [W-1:0] obs_inst0;
  logic [3:0]   obs_count;

  inst_queue dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .enq_inst_i      (enq_inst_i),
    .enq_valid_i     (enq_valid_i),
    .enq_ready_o     (enq_ready_o),
    .deq_inst_o      (deq_inst_o),
    .deq_valid_o     (deq_valid_o),
    .issue_num_i     (issue_num_i),
    .backend_stall_i (backend_stall_i),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd_inst();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: drive inputs, sample pre-edge outputs, update model at the edge, go idle.
  task automatic cyc(input logic f, input logic [1:0] v, input logic [W-1:0] d0,
                     input logic [W-1:0] d1, input logic [1:0] iss, input logic st);
    int sz, n, avail, pops;
    logic [W-1:0] inc[$];
    flush_i = f; enq_valid_i = v; enq_inst_i = {d1, d0};
    issue_num_i = iss; backend_stall_i = st;
    #1;
    obs_valid = deq_valid_o; obs_inst0 = deq_inst_o[W-1:0]; obs_count = count_o;
    sz = mq.size();
    inc.delete();
    if (v[0]) inc.push_back(d0);
    if (v[1]) inc.push_back(d1);
    @(posedge clk);
    if (f) mq.delete();
    else begin
      n = st ? 0 : ((iss == 2'd3) ? 2 : int'(iss));
      avail = sz;
`ifdef INST_QUEUE_BYPASS_EN
      if (sz == 0) avail = inc.size();
`endif
      pops = (n < avail) ? n : avail;
      if (8 - sz >= 2) foreach (inc[i]) mq.push_back(inc[i]);
      repeat (pops) void'(mq.pop_front());
    end
    #1;
    flush_i = 1'b0; enq_valid_i = 2'b00; issue_num_i = 2'd0; backend_stall_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; enq_valid_i = 2'b00; enq_inst_i = '0;
    issue_num_i = 2'd0; backend_stall_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count act=%0d exp=0", count_o); end
    checks++; if (deq_valid_o !== 2'b00) begin errors++; $display("FAIL reset_valid act=%b exp=00", deq_valid_o); end
    checks++; if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready act=%b exp=1", enq_ready_o); end
    rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
  endtask

  task automatic test_enq_pair();
    logic [W-1:0] a, b;
    a = rnd_inst(); b = rnd_inst();
    cyc(0, 2'b11, a, b, 2'd0, 0);
    checks++; if (deq_valid_o !== 2'b11) begin errors++; $display("FAIL pair_valid act=%b exp=11", deq_valid_o); end
    checks++; if (deq_inst_o !== {b, a}) begin errors++; $display("FAIL pair_inst act=%h exp=%h", deq_inst_o, {b, a}); end
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL pair_count act=%0d exp=2", count_o); end
    checks++; if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL pair_ready act=%b exp=1", enq_ready_o); end
  endtask

  task automatic test_fill();
    logic [W-1:0] h0, h1;
    repeat (3) cyc(0, 2'b11, rnd_inst(), rnd_inst(), 2'd0, 0);
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_count act=%0d exp=8", count_o); end
    checks++; if (enq_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready act=%b exp=0", enq_ready_o); end
    h0 = rnd_inst(); h1 = rnd_inst();
    repeat (3) cyc(0, 2'b11, h0, h1, 2'd0, 0);
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL held_count act=%0d exp=8", count_o); end
    // A full queue popping two must still refuse the packet offered that cycle.
    cyc(0, 2'b11, h0, h1, 2'd2, 0);
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL full_pop_count act=%0d exp=6", count_o); end
    while (mq.size() > 0) begin
      checks++;
      if (deq_inst_o[W-1:0] !== mq[0]) begin errors++; $display("FAIL drain_order act=%h exp=%h", deq_inst_o[W-1:0], mq[0]); end
      cyc(0, 2'b00, '0, '0, 2'd1, 0);
    end
  endtask

  task automatic test_pop_stall();
    logic [W-1:0] c;
    cyc(1, 2'b00, '0, '0, 2'd0, 0);
    c = rnd_inst();
    cyc(0, 2'b11, rnd_inst(), rnd_inst(), 2'd0, 0);
    cyc(0, 2'b01, c, rnd_inst(), 2'd0, 0);
    cyc(0, 2'b00, '0, '0, 2'd2, 1);
    checks++; if (count_o !== 4'd3) begin errors++; $display("FAIL stall_count act=%0d exp=3", count_o); end
    cyc(0, 2'b00, '0, '0, 2'd2, 0);
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL pop2_count act=%0d exp=1", count_o); end
    checks++; if (deq_inst_o[W-1:0] !== c) begin errors++; $display("FAIL pop2_inst act=%h exp=%h", deq_inst_o[W-1:0], c); end
    checks++; if (deq_valid_o !== 2'b01) begin errors++; $display("FAIL pop2_valid act=%b exp=01", deq_valid_o); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] x, y;
    cyc(1, 2'b00, '0, '0, 2'd0, 0);
    repeat (3) cyc(0, 2'b11, rnd_inst(), rnd_inst(), 2'd0, 0);
    cyc(0, 2'b01, rnd_inst(), '0, 2'd0, 0);
    repeat (3) cyc(0, 2'b00, '0, '0, 2'd2, 0);
    cyc(0, 2'b00, '0, '0, 2'd1, 0);
    repeat (3) cyc(0, 2'b11, rnd_inst(), rnd_inst(), 2'd0, 0);
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL wrap_pre_count act=%0d exp=6", count_o); end
    x = rnd_inst(); y = rnd_inst();
    cyc(0, 2'b11, x, y, 2'd2, 0);
    checks++; if (count_o !== 4'd6) begin errors++; $display("FAIL wrap_count act=%0d exp=6", count_o); end
    checks++; if (mq[4] !== x || mq[5] !== y) begin errors++; $display("FAIL wrap_model_xy act=%h exp=%h", {mq[5], mq[4]}, {y, x}); end
    while (mq.size() > 0) begin
      checks++;
      if (deq_inst_o[W-1:0] !== mq[0]) begin errors++; $display("FAIL wrap_order act=%h exp=%h", deq_inst_o[W-1:0], mq[0]); end
      cyc(0, 2'b00, '0, '0, 2'd1, 0);
    end
  endtask

  task automatic test_flush();
    repeat (2) cyc(0, 2'b11, rnd_inst(), rnd_inst(), 2'd0, 0);
    cyc(0, 2'b01, rnd_inst(), '0, 2'd0, 0);
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL preflush_count act=%0d exp=5", count_o); end
    cyc(1, 2'b11, rnd_inst(), rnd_inst(), 2'd2, 0);
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL flush_count act=%0d exp=0", count_o); end
    checks++; if (deq_valid_o !== 2'b00) begin errors++; $display("FAIL flush_valid act=%b exp=00", deq_valid_o); end
    checks++; if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready act=%b exp=1", enq_ready_o); end
  endtask

  task automatic test_single_slot();
    logic [W-1:0] z;
    z = rnd_inst();
    cyc(0, 2'b10, rnd_inst(), z, 2'd0, 0);
    checks++; if (count_o !== 4'd1) begin errors++; $display("FAIL slot1_count act=%0d exp=1", count_o); end
    checks++; if (deq_inst_o[W-1:0] !== z) begin errors++; $display("FAIL slot1_inst act=%h exp=%h", deq_inst_o[W-1:0], z); end
    checks++; if (deq_valid_o !== 2'b01) begin errors++; $display("FAIL slot1_valid act=%b exp=01", deq_valid_o); end
`ifdef INST_QUEUE_BYPASS_EN
    cyc(1, 2'b00, '0, '0, 2'd0, 0);
    z = rnd_inst();
    cyc(0, 2'b10, rnd_inst(), z, 2'd1, 0);
    checks++; if (obs_inst0 !== z) begin errors++; $display("FAIL byp_inst act=%h exp=%h", obs_inst0, z); end
    checks++; if (obs_valid !== 2'b01) begin errors++; $display("FAIL byp_valid act=%b exp=01", obs_valid); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL byp_count act=%0d exp=0", count_o); end
`endif
  endtask

  task automatic test_random();
    logic [3:0] exp_cnt;
    logic [1:0] exp_v;
    cyc(1, 2'b00, '0, '0, 2'd0, 0);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), rnd_inst(), rnd_inst(),
          2'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
      exp_cnt = 4'(mq.size());
      exp_v   = {mq.size() >= 2, mq.size() >= 1};
      checks++; if (count_o !== exp_cnt) begin errors++; $display("FAIL rnd_count i=%0d act=%0d exp=%0d", i, count_o, exp_cnt); end
      checks++; if (deq_valid_o !== exp_v) begin errors++; $display("FAIL rnd_valid i=%0d act=%b exp=%b", i, deq_valid_o, exp_v); end
      checks++; if (enq_ready_o !== (mq.size() <= 6)) begin errors++; $display("FAIL rnd_ready i=%0d act=%b", i, enq_ready_o); end
      if (mq.size() >= 1) begin
        checks++; if (deq_inst_o[W-1:0] !== mq[0]) begin errors++; $display("FAIL rnd_inst0 i=%0d act=%h exp=%h", i, deq_inst_o[W-1:0], mq[0]); end
      end
      if (mq.size() >= 2) begin
        checks++; if (deq_inst_o[2*W-1:W] !== mq[1]) begin errors++; $display("FAIL rnd_inst1 i=%0d act=%h exp=%h", i, deq_inst_o[2*W-1:W], mq[1]); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_enq_pair();
    test_fill();
    test_pop_stall();
    test_wrap();
    cyc(1, 2'b00, '0, '0, 2'd0, 0);
    test_flush();
    test_single_slot();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
